// File: rtl/sobel_stream_pipeline.sv
// Multi-channel 3x3 Sobel filter on a raster pixel stream: line buffers + window,
// registered gradients, then a saturated-magnitude or threshold output register.
module sobel_stream_pipeline #(
    parameter int WIDTH_P      = 640,
    parameter int HEIGHT_P     = 480,
    parameter int CHANNELS_P   = 1,
    parameter int PIXEL_BITS_P = 8,
    parameter int BUS_BITS_P   = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    mode_i,
    input  logic [PIXEL_BITS_P-1:0] thresh_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [BUS_BITS_P-1:0]   pixel_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [BUS_BITS_P-1:0]   pixel_o,
    output logic                    last_o
);

    localparam int COL_W     = (WIDTH_P > 1) ? $clog2(WIDTH_P) : 1;
    localparam int ROW_W     = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;
    localparam int USED_BITS = CHANNELS_P * PIXEL_BITS_P;
    localparam int SUM_W     = PIXEL_BITS_P + 3;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH_P - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT_P - 1);
    localparam logic [SUM_W-1:0] PIX_MAX  = {3'b000, {PIXEL_BITS_P{1'b1}}};

    typedef logic        [PIXEL_BITS_P-1:0] pix_t;
    typedef logic signed [SUM_W-1:0]        grad_t;

    if (USED_BITS > BUS_BITS_P) begin : g_bus_check
        $error("sobel_stream_pipeline: CHANNELS_P*PIXEL_BITS_P exceeds BUS_BITS_P");
    end

    function automatic grad_t ext(input pix_t p);
        return grad_t'({3'b000, p});
    endfunction

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic                  adv;
    logic                  accept;
    logic                  win_fire;
    logic                  win_last;
    logic                  mode_q;
    pix_t                  thresh_q;
    logic                  s1_valid;
    logic                  s1_last;
    logic                  s1_mode;
    pix_t                  s1_thresh;
    logic [BUS_BITS_P-1:0] pixel_d;

    // The whole pipeline, window included, moves only when the output slot can take a word.
    assign adv      = !valid_o || ready_i;
    assign ready_o  = adv;
    assign accept   = valid_i && adv;
    assign win_fire = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign win_last = (row == ROW_LAST) && (col == COL_LAST);

    for (genvar ch = 0; ch < CHANNELS_P; ch++) begin : g_ch
        pix_t  lb_top [WIDTH_P];
        pix_t  lb_mid [WIDTH_P];
        pix_t  win    [3][2];
        pix_t  top;
        pix_t  mid;
        pix_t  bot;
        grad_t gx_d;
        grad_t gy_d;
        grad_t s_gx;
        grad_t s_gy;
        grad_t ax;
        grad_t ay;
        logic [SUM_W-1:0] mag;
        pix_t  sat;
        pix_t  lane;

        assign bot = pixel_i[ch*PIXEL_BITS_P +: PIXEL_BITS_P];
        assign top = lb_top[col];
        assign mid = lb_mid[col];

        // NOTE: line buffers and window carry no reset; rows 0-1 and columns 0-1 of each frame
        // overwrite them before any window that reads them is marked valid.
        always_ff @(posedge clk_i) begin
            if (accept) begin
                lb_top[col] <= mid;
                lb_mid[col] <= bot;
                win[0][0]   <= win[0][1];
                win[0][1]   <= top;
                win[1][0]   <= win[1][1];
                win[1][1]   <= mid;
                win[2][0]   <= win[2][1];
                win[2][1]   <= bot;
            end
            if (adv) begin
                s_gx <= gx_d;
                s_gy <= gy_d;
            end
        end

        // Window columns: [*][0] = col-2, [*][1] = col-1, incoming top/mid/bot = col.
        always_comb begin
            gx_d = (ext(top) + (ext(mid) << 1) + ext(bot))
                 - (ext(win[0][0]) + (ext(win[1][0]) << 1) + ext(win[2][0]));
            gy_d = (ext(win[2][0]) + (ext(win[2][1]) << 1) + ext(bot))
                 - (ext(win[0][0]) + (ext(win[0][1]) << 1) + ext(top));
        end

        // NOTE: every variable gets a value on every path through this block, so no latch is inferred.
        always_comb begin
            ax   = s_gx[SUM_W-1] ? -s_gx : s_gx;
            ay   = s_gy[SUM_W-1] ? -s_gy : s_gy;
            mag  = $unsigned(ax) + $unsigned(ay);
            sat  = (mag > PIX_MAX) ? '1 : mag[PIXEL_BITS_P-1:0];
            lane = sat;
            if (s1_mode) begin
                lane = (mag >= {3'b000, s1_thresh}) ? '1 : '0;
            end
        end

        assign pixel_d[ch*PIXEL_BITS_P +: PIXEL_BITS_P] = lane;
    end

    if (USED_BITS < BUS_BITS_P) begin : g_pad
        logic unused_pixel_hi;
        assign pixel_d[BUS_BITS_P-1:USED_BITS] = '0;
        assign unused_pixel_hi = ^pixel_i[BUS_BITS_P-1:USED_BITS];
    end

    always_ff @(posedge clk_i) begin
        // NOTE: all sequential state uses <=, so each stage samples the previous stage's pre-edge value.
        if (reset_i) begin
            col       <= '0;
            row       <= '0;
            mode_q    <= 1'b0;
            thresh_q  <= '0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_mode   <= 1'b0;
            s1_thresh <= '0;
            valid_o   <= 1'b0;
            last_o    <= 1'b0;
            pixel_o   <= '0;
        end else begin
            if (accept) begin
                if ((row == '0) && (col == '0)) begin
                    mode_q   <= mode_i;
                    thresh_q <= thresh_i;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end
            if (adv) begin
                s1_valid  <= win_fire;
                s1_last   <= win_last;
                s1_mode   <= mode_q;
                s1_thresh <= thresh_q;
                valid_o   <= s1_valid;
                last_o    <= s1_valid && s1_last;
                if (s1_valid) begin
                    pixel_o <= pixel_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_pipeline.sv
// Self-checking bench for sobel_stream_pipeline: table-driven frames, lane, mode-latch,
// randomized handshake against a kernel-sum reference model, and mid-frame reset.
module tb_sobel_stream_pipeline;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int CH = 3;
    localparam int PB = 8;
    localparam int BB = 64;

    typedef logic [7:0] img_t [CH][H][W];
    typedef struct {
        logic [63:0] data;
        logic        last;
    } out_t;
    typedef struct {
        int   pat;
        logic mode;
        int   thr;
        int   e0;
        int   e1;
        int   e2;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          mode_i = 1'b0;
    logic [PB-1:0] thresh_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic [BB-1:0] pixel_i = '0;
    logic          valid_o;
    logic          ready_i = 1'b1;
    logic [BB-1:0] pixel_o;
    logic          last_o;

    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;
    int   force_low = 0;
    out_t got[$];
    out_t exp_q[$];

    sobel_stream_pipeline #(
        .WIDTH_P(W), .HEIGHT_P(H), .CHANNELS_P(CH), .PIXEL_BITS_P(PB), .BUS_BITS_P(BB)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .mode_i(mode_i), .thresh_i(thresh_i),
        .valid_i(valid_i), .ready_o(ready_o), .pixel_i(pixel_i),
        .valid_o(valid_o), .ready_i(ready_i), .pixel_o(pixel_o), .last_o(last_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Downstream ready: always high, random, or held low; force_low overrides for a few cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (force_low > 0) begin
                ready_i = 1'b0;
                force_low--;
            end else begin
                case (ready_mode)
                    1:       ready_i = ($urandom_range(0, 3) != 0);
                    2:       ready_i = 1'b0;
                    default: ready_i = 1'b1;
                endcase
            end
        end
    end

    // Output monitor: collects handshaked words, checks hold while stalled and ready_o.
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic        prev_last;
    always @(negedge clk) begin
        if (reset_i) begin
            prev_stall = 1'b0;
        end else begin
            check("ready_o vs stall", 64'(ready_o), 64'(!(valid_o && !ready_i)));
            if (prev_stall) begin
                check("hold valid_o", 64'(valid_o), 64'd1);
                check("hold pixel_o", pixel_o, prev_data);
                check("hold last_o", 64'(last_o), 64'(prev_last));
            end
            if (valid_o && ready_i) got.push_back('{pixel_o, last_o});
            prev_stall = valid_o && !ready_i;
            prev_data  = pixel_o;
            prev_last  = last_o;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic img_t make_img(input int p0, input int p1, input int p2);
        img_t img;
        int   pat;
        for (int ch = 0; ch < CH; ch++) begin
            pat = (ch == 0) ? p0 : (ch == 1) ? p1 : p2;
            for (int r = 0; r < H; r++) begin
                for (int c = 0; c < W; c++) begin
                    case (pat)
                        0:       img[ch][r][c] = 8'd100;
                        1:       img[ch][r][c] = (c < 2) ? 8'd0 : 8'd10;
                        2:       img[ch][r][c] = (c < 2) ? 8'd0 : 8'd255;
                        default: img[ch][r][c] = 8'($urandom);
                    endcase
                end
            end
        end
        return img;
    endfunction

    // Reference: Sobel kernel weights applied to each interior centre, plain integer arithmetic.
    function automatic void model_frame(input img_t img, input logic mode, input int thr);
        out_t o;
        int   gx, gy, p, mag, v;
        for (int r = 1; r <= H - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                o.data = '0;
                for (int ch = 0; ch < CH; ch++) begin
                    gx = 0;
                    gy = 0;
                    for (int dr = -1; dr <= 1; dr++) begin
                        for (int dc = -1; dc <= 1; dc++) begin
                            p  = int'(img[ch][r+dr][c+dc]);
                            gx += dc * ((dr == 0) ? 2 : 1) * p;
                            gy += dr * ((dc == 0) ? 2 : 1) * p;
                        end
                    end
                    mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
                    if (mag > 255) mag = 255;
                    v = mode ? ((mag >= thr) ? 255 : 0) : mag;
                    o.data[ch*PB +: PB] = 8'(v);
                end
                o.last = (r == H - 2) && (c == W - 2);
                exp_q.push_back(o);
            end
        end
    endfunction

    task automatic send_pixel(input logic [63:0] word);
        int guard;
        guard   = 0;
        valid_i = 1'b1;
        pixel_i = word;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL input handshake: ready_o stuck low for %0d cycles, expected accept", guard);
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic send_frame(input img_t img, input logic mode, input int thr, input bit scramble,
                              input bit rnd, input int npix, input int stall_idx);
        logic [63:0] w;
        int          r, c;
        mode_i   = mode;
        thresh_i = 8'(thr);
        for (int i = 0; i < npix; i++) begin
            r = i / W;
            c = i % W;
            if (rnd) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (i == stall_idx) force_low = 3;
            w = '0;
            for (int ch = 0; ch < CH; ch++) w[ch*PB +: PB] = img[ch][r][c];
            send_pixel(w);
            if (i == 0 && scramble) begin
                mode_i   = ~mode;
                thresh_i = 8'($urandom);
            end
        end
    endtask

    task automatic wait_outputs(input int n);
        int guard;
        guard = 0;
        while (got.size() < n && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("output word count", 64'(got.size()), 64'(n));
    endtask

    task automatic compare_model(input string tag);
        int n;
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        check({tag, " count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s data[%0d]", tag, i), got[i].data, exp_q[i].data);
            check($sformatf("%s last[%0d]", tag, i), 64'(got[i].last), 64'(exp_q[i].last));
        end
        got.delete();
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("valid_o after reset", 64'(valid_o), 64'd0);
        check("last_o after reset", 64'(last_o), 64'd0);
        @(posedge clk);
        #1;
        got.delete();
        exp_q.delete();
    endtask

    vec_t        vecs[7];
    img_t        img;
    logic [63:0] ew;
    int          e;
    int          lane_exp [CH][3];
    logic        rmode;
    int          rthr;

    initial begin
        vecs[0] = '{0, 1'b0, 0,  0,   0,   0};
        vecs[1] = '{1, 1'b0, 0,  40,  40,  0};
        vecs[2] = '{2, 1'b0, 0,  255, 255, 0};
        vecs[3] = '{1, 1'b1, 30, 255, 255, 0};
        vecs[4] = '{1, 1'b1, 40, 255, 255, 0};
        vecs[5] = '{1, 1'b1, 41, 0,   0,   0};
        vecs[6] = '{0, 1'b1, 0,  255, 255, 255};

        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("reset valid_o", 64'(valid_o), 64'd0);
        check("reset last_o", 64'(last_o), 64'd0);
        check("reset pixel_o", pixel_o, 64'd0);
        check("reset ready_o", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;

        // Table-driven frames: same image on every lane, expectations are hand-derived constants.
        for (int v = 0; v < 7; v++) begin
            img = make_img(vecs[v].pat, vecs[v].pat, vecs[v].pat);
            got.delete();
            send_frame(img, vecs[v].mode, vecs[v].thr, 1'b0, 1'b0, W * H, -1);
            wait_outputs(6);
            for (int i = 0; i < 6 && i < got.size(); i++) begin
                e  = (i % 3 == 0) ? vecs[v].e0 : (i % 3 == 1) ? vecs[v].e1 : vecs[v].e2;
                ew = '0;
                for (int ch = 0; ch < CH; ch++) ew[ch*PB +: PB] = 8'(e);
                check($sformatf("vec%0d data[%0d]", v, i), got[i].data, ew);
                check($sformatf("vec%0d last[%0d]", v, i), 64'(got[i].last), 64'(i == 5));
            end
            got.delete();
        end

        // Distinct image per lane; each lane matches its single-channel result, upper bits zero.
        lane_exp[0] = '{0, 0, 0};
        lane_exp[1] = '{40, 40, 0};
        lane_exp[2] = '{255, 255, 0};
        img = make_img(0, 1, 2);
        send_frame(img, 1'b0, 0, 1'b0, 1'b0, W * H, -1);
        wait_outputs(6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            ew = '0;
            for (int ch = 0; ch < CH; ch++) ew[ch*PB +: PB] = 8'(lane_exp[ch][i % 3]);
            check($sformatf("lanes data[%0d]", i), got[i].data, ew);
        end
        got.delete();

        // Mode flips to 0 right after (0,0) of a threshold frame; next frame follows with no gap.
        img = make_img(1, 1, 1);
        send_frame(img, 1'b1, 30, 1'b1, 1'b0, W * H, -1);
        send_frame(img, 1'b0, 30, 1'b0, 1'b0, W * H, -1);
        wait_outputs(12);
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            e  = (i < 6) ? ((i % 3 == 2) ? 0 : 255) : ((i % 3 == 2) ? 0 : 40);
            ew = '0;
            for (int ch = 0; ch < CH; ch++) ew[ch*PB +: PB] = 8'(e);
            check($sformatf("mode latch data[%0d]", i), got[i].data, ew);
            check($sformatf("mode latch last[%0d]", i), 64'(got[i].last), 64'(i == 5 || i == 11));
        end
        got.delete();

        // Random images, modes, valid gaps and ready, three frames back to back.
        ready_mode = 1;
        for (int f = 0; f < 3; f++) begin
            img   = make_img(3, 3, 3);
            rmode = 1'($urandom_range(0, 1));
            rthr  = int'($urandom_range(0, 255));
            model_frame(img, rmode, rthr);
            send_frame(img, rmode, rthr, 1'b1, 1'b1, W * H, (f == 1) ? 13 : -1);
        end
        wait_outputs(18);
        ready_mode = 0;
        compare_model("random");

        // Reset after 7 accepted pixels, then a clean frame.
        img = make_img(3, 3, 3);
        send_frame(img, 1'b0, 0, 1'b0, 1'b0, 7, -1);
        pulse_reset();
        img = make_img(3, 3, 3);
        model_frame(img, 1'b1, 90);
        send_frame(img, 1'b1, 90, 1'b0, 1'b0, W * H, -1);
        wait_outputs(6);
        compare_model("after reset 7");

        // Reset while a finished window is stalled at the output.
        ready_mode = 2;
        img = make_img(3, 3, 3);
        send_frame(img, 1'b0, 0, 1'b0, 1'b0, 14, -1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("stalled valid_o before reset", 64'(valid_o), 64'd1);
        ready_mode = 0;
        pulse_reset();
        img = make_img(3, 3, 3);
        model_frame(img, 1'b0, 0);
        send_frame(img, 1'b0, 0, 1'b0, 1'b0, W * H, -1);
        wait_outputs(6);
        compare_model("after reset stalled");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
